regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Multi-cycle control sequencer for the 4-bit processor. It fetches a 16-bit instruction, drives the register file's read addresses (`Rd1`, `Rd2`), and captures the ALU result. It then issues a single-cycle `RegWrite` with `Wr` and `Write_data`, gated by ALU overflow. It sits between instruction memory, the register file and the ALU, and is the only writer of register-file control signals.

## Interface
- `PC_W`, 4: program-counter width; the instruction space is 2^PC_W words.
- `HALT_OP`, 4'hF: opcode that stops execution.
- `LDI_OP`, 4'hE: load-immediate opcode, which bypasses the ALU.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `run`  in  1  level; continuous execution while high.
- `step`  in  1  single-cycle pulse; executes exactly one instruction when idle.
- `instr`  in  16  instruction word at `pc` (combinational memory). Fields: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm.
- `pc`  out  PC_W  program counter.
- `alu_result`  in  4  ALU output.
- `alu_overflow`  in  1  ALU overflow for the current operation.
- `alu_op`  out  4  ALU operation select.
- `Rd1`  out  4  register-file read address 1.
- `Rd2`  out  4  register-file read address 2.
- `Wr`  out  4  register-file write address.
- `Write_data`  out  4  register-file write data.
- `RegWrite`  out  1  register-file write enable.
- `ovf_flag`  out  1  sticky overflow indicator.
- `halted`  out  1  high in HALT.
- `busy`  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - Go to FETCH if `run` or `step` is high; otherwise stay.
  - `step` is sampled only in IDLE. A `step` in any other state is ignored.
- FETCH: latch `instr` into the internal IR. Next state is DECODE.
- DECODE: drive `Rd1`=IR.rs1, `Rd2`=IR.rs2, `alu_op`=IR.op.
  - op = `HALT_OP`: go to HALT; `pc` is not incremented.
  - op = 4'h0 (NOP): go to WRITEBACK with the write suppressed.
  - Otherwise: go to EXECUTE.
- EXECUTE: `Rd1`, `Rd2` and `alu_op` are held. Capture the write-back data:
  - For `LDI_OP`: data = IR[3:0], overflow = 0.
  - Otherwise: data = `alu_result`, overflow = `alu_overflow`.
  - Next state is WRITEBACK.
- WRITEBACK:
  - `Wr`=IR.rd and `Write_data`=captured data.
  - `RegWrite`=1 only if op≠NOP, rd≠0 and captured overflow=0.
  - If captured overflow=1: no write, and `ovf_flag` is set. It stays set until `rst`.
  - `pc` ← `pc`+1 mod 2^PC_W, so 15 wraps to 0 for PC_W=4.
  - Next state is FETCH if `run` is high, else IDLE.
- HALT: `halted`=1. All write strobes are 0. The block leaves HALT only on `rst`, and ignores `run` and `step`.
- `run` falling mid-instruction: the current instruction completes through WRITEBACK, then the block goes to IDLE. No instruction is abandoned.
- `rst` in any state, including WRITEBACK: state, outputs and IR reset on that edge. No write is issued in the cycle following reset.
- Register 0 is never targeted: `RegWrite` stays 0 for rd=0 even when the result is valid.

## Timing
- Reset values: `pc`=0, `Rd1`=`Rd2`=`Wr`=`Write_data`=`alu_op`=0, `RegWrite`=0, `ovf_flag`=0, `halted`=0, `busy`=0, state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `instr`, `run`, `step` or the ALU inputs to any output.
- ALU and LDI instructions take 4 cycles (FETCH→WRITEBACK). NOP takes 3 cycles. HALT takes 2 cycles to reach HALT.
- Under continuous `run`, the instruction throughput is one instruction per 4 cycles.
- `RegWrite` is high for exactly one cycle per writing instruction. `Wr` and `Write_data` are stable for that whole cycle, and the register file samples at its closing edge.
- `Rd1` and `Rd2` are stable from DECODE through EXECUTE, so the register-file read and ALU result settle within one cycle.
- A result written in WRITEBACK is visible to the next instruction's DECODE read, with no hazard.
- `step` taken in IDLE: first FETCH in the next cycle. Return to IDLE 4 cycles after FETCH, assuming `run`=0.

## Test plan
- Reset then `step`, with `instr`=16'hE305 (LDI r3,5): `RegWrite`=1 in cycle 4 only, with `Wr`=3, `Write_data`=5. Then `pc`=1, back in IDLE, `busy`=0.
- `run`=1 with program ADD r4,r1,r2 (16'h1412), `alu_result`=4'h7, `alu_overflow`=0: write `Wr`=4, `Write_data`=7. Next FETCH occurs immediately after WRITEBACK.
- Same ADD with `alu_overflow`=1: `RegWrite` stays 0 for the whole instruction. `ovf_flag`=1 from WRITEBACK+1 and persists through later instructions until `rst`.
- Instruction 16'hE007 (LDI r0,7) followed by NOP 16'h0000: no `RegWrite` pulse for either. NOP completes in 3 cycles and `pc` advances by 2 in total.
- `run` held for 16 instructions from `pc`=0: `pc` wraps 15→0. Then 16'hF000: `halted`=1 with `pc` frozen, and `run`/`step` have no effect until `rst`.
- `rst` asserted during WRITEBACK of a writing instruction: the following cycle has `RegWrite`=0 and all outputs at reset values. `run` deassertion mid-EXECUTE still completes that write, then the block goes to IDLE.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction, drives register-file
// read addresses and ALU op, captures the result, then issues a single-cycle
// register-file write gated by ALU overflow.
module regfile_sequencer #(
    parameter int unsigned PC_W    = 4,
    parameter logic [3:0]  HALT_OP = 4'hF,
    parameter logic [3:0]  LDI_OP  = 4'hE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    input  logic [15:0]     instr,
    output logic [PC_W-1:0] pc,
    input  logic [3:0]      alu_result,
    input  logic            alu_overflow,
    output logic [3:0]      alu_op,
    output logic [3:0]      Rd1,
    output logic [3:0]      Rd2,
    output logic [3:0]      Wr,
    output logic [3:0]      Write_data,
    output logic            RegWrite,
    output logic            ovf_flag,
    output logic            halted,
    output logic            busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    localparam logic [3:0] NopOp = 4'h0;

    state_e          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      wdata_q, wdata_d;
    logic            ovf_cap_q, ovf_cap_d;
    logic            reg_write_q, reg_write_d;
    logic            ovf_flag_q, ovf_flag_d;

    logic            ovf_now;
    logic [3:0]      data_now;

    // Next-state logic: sequencing, IR latch, write-back capture and pc update.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        wdata_d     = wdata_q;
        ovf_cap_d   = ovf_cap_q;
        reg_write_d = 1'b0;
        ovf_flag_d  = ovf_flag_q;
        ovf_now     = 1'b0;
        data_now    = 4'h0;

        case (state_q)
            StIdle: begin
                if (run || step) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = instr;
                state_d = StDecode;
            end
            StDecode: begin
                ovf_cap_d = 1'b0;
                if (ir_q[15:12] == HALT_OP) begin
                    state_d = StHalt;
                end else if (ir_q[15:12] == NopOp) begin
                    // NOP goes straight to write-back with the strobe held low.
                    wdata_d = 4'h0;
                    state_d = StWriteback;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (ir_q[15:12] == LDI_OP) begin
                    data_now = ir_q[3:0];
                    ovf_now  = 1'b0;
                end else begin
                    data_now = alu_result;
                    ovf_now  = alu_overflow;
                end
                wdata_d     = data_now;
                ovf_cap_d   = ovf_now;
                // Register 0 is never a write target.
                reg_write_d = (ir_q[11:8] != 4'h0) && !ovf_now;
                state_d     = StWriteback;
            end
            StWriteback: begin
                pc_d = pc_q + PC_W'(1);
                if (ovf_cap_q) begin
                    ovf_flag_d = 1'b1;
                end
                state_d = run ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ir_q        <= 16'h0000;
            pc_q        <= '0;
            wdata_q     <= 4'h0;
            ovf_cap_q   <= 1'b0;
            reg_write_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            wdata_q     <= wdata_d;
            ovf_cap_q   <= ovf_cap_d;
            reg_write_q <= reg_write_d;
            ovf_flag_q  <= ovf_flag_d;
        end
    end

    // Outputs come only from registers; IR fields hold steady through
    // DECODE, EXECUTE and WRITEBACK.
    always_comb begin
        pc         = pc_q;
        alu_op     = ir_q[15:12];
        Rd1        = ir_q[7:4];
        Rd2        = ir_q[3:0];
        Wr         = ir_q[11:8];
        Write_data = wdata_q;
        RegWrite   = reg_write_q;
        ovf_flag   = ovf_flag_q;
        halted     = (state_q == StHalt);
        busy       = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StExecute) || (state_q == StWriteback);
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a write scoreboard: expected
// register writes are queued as instructions are set up and popped whenever
// the DUT pulses RegWrite.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic [15:0] instr;
    logic [3:0]  pc;
    logic [3:0]  alu_result;
    logic        alu_overflow;
    logic [3:0]  alu_op;
    logic [3:0]  Rd1;
    logic [3:0]  Rd2;
    logic [3:0]  Wr;
    logic [3:0]  Write_data;
    logic        RegWrite;
    logic        ovf_flag;
    logic        halted;
    logic        busy;

    logic [15:0] mem [16];
    logic [7:0]  sb [$];
    int          total = 0;
    int          bad   = 0;

    assign instr = mem[pc];

    regfile_sequencer #(
        .PC_W    (4),
        .HALT_OP (4'hF),
        .LDI_OP  (4'hE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step         (step),
        .instr        (instr),
        .pc           (pc),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_op       (alu_op),
        .Rd1          (Rd1),
        .Rd2          (Rd2),
        .Wr           (Wr),
        .Write_data   (Write_data),
        .RegWrite     (RegWrite),
        .ovf_flag     (ovf_flag),
        .halted       (halted),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every RegWrite pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {8'h00, Wr, Write_data}, 16'hFFFF);
            end else begin
                check("write_wr_data", {8'h00, Wr, Write_data}, {8'h00, sb.pop_front()});
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst = 1'b1; run = 1'b0; step = 1'b0; alu_result = 4'h0; alu_overflow = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        check("rst_pc", 16'(pc), 16'h0);
        check("rst_rd1", 16'(Rd1), 16'h0);
        check("rst_rd2", 16'(Rd2), 16'h0);
        check("rst_wr", 16'(Wr), 16'h0);
        check("rst_wdata", 16'(Write_data), 16'h0);
        check("rst_aluop", 16'(alu_op), 16'h0);
        check("rst_regwrite", 16'(RegWrite), 16'h0);
        check("rst_ovf", 16'(ovf_flag), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // Single step: LDI r3,5
        mem[0] = 16'hE305;
        sb.push_back(8'h35);
        step = 1'b1;
        tick();                                  // FETCH
        step = 1'b0;
        check("step_fetch_busy", 16'(busy), 16'h1);
        check("step_fetch_rw", 16'(RegWrite), 16'h0);
        tick();                                  // DECODE
        check("step_dec_rd1", 16'(Rd1), 16'h0);
        check("step_dec_rd2", 16'(Rd2), 16'h5);
        check("step_dec_aluop", 16'(alu_op), 16'hE);
        check("step_dec_rw", 16'(RegWrite), 16'h0);
        tick();                                  // EXECUTE
        check("step_exe_rw", 16'(RegWrite), 16'h0);
        tick();                                  // WRITEBACK
        check("step_wb_rw", 16'(RegWrite), 16'h1);
        check("step_wb_wr", 16'(Wr), 16'h3);
        check("step_wb_data", 16'(Write_data), 16'h5);
        tick();                                  // IDLE
        check("step_idle_rw", 16'(RegWrite), 16'h0);
        check("step_idle_pc", 16'(pc), 16'h1);
        check("step_idle_busy", 16'(busy), 16'h0);

        // Run: ADD r4,r1,r2 without then with overflow
        mem[1] = 16'h1412;
        mem[2] = 16'h1412;
        alu_result = 4'h7;
        sb.push_back(8'h47);
        run = 1'b1;
        tick();                                  // FETCH
        tick();                                  // DECODE
        check("add_dec_rd1", 16'(Rd1), 16'h1);
        check("add_dec_rd2", 16'(Rd2), 16'h2);
        check("add_dec_aluop", 16'(alu_op), 16'h1);
        tick();                                  // EXECUTE
        tick();                                  // WRITEBACK
        check("add_wb_rw", 16'(RegWrite), 16'h1);
        check("add_wb_wr", 16'(Wr), 16'h4);
        check("add_wb_data", 16'(Write_data), 16'h7);
        tick();                                  // FETCH immediately
        check("add_refetch_busy", 16'(busy), 16'h1);
        check("add_refetch_pc", 16'(pc), 16'h2);
        alu_overflow = 1'b1;
        run = 1'b0;
        tick(); tick();                          // DECODE, EXECUTE
        check("ovf_exe_rw", 16'(RegWrite), 16'h0);
        tick();                                  // WRITEBACK
        check("ovf_wb_rw", 16'(RegWrite), 16'h0);
        check("ovf_wb_flag", 16'(ovf_flag), 16'h0);
        tick();                                  // IDLE
        check("ovf_after_flag", 16'(ovf_flag), 16'h1);
        check("ovf_after_pc", 16'(pc), 16'h3);
        check("ovf_after_busy", 16'(busy), 16'h0);
        alu_overflow = 1'b0;

        // LDI r0,7 then NOP: no writes, NOP in 3 cycles
        mem[3] = 16'hE007;
        mem[4] = 16'h0000;
        run = 1'b1;
        tick(); tick(); tick(); tick();          // F D E WB
        check("ldi_r0_wb_rw", 16'(RegWrite), 16'h0);
        tick();                                  // FETCH of NOP
        check("nop_fetch_pc", 16'(pc), 16'h4);
        run = 1'b0;
        tick(); tick();                          // DECODE, WRITEBACK
        check("nop_wb_rw", 16'(RegWrite), 16'h0);
        check("nop_wb_busy", 16'(busy), 16'h1);
        tick();                                  // IDLE
        check("nop_idle_pc", 16'(pc), 16'h5);
        check("nop_idle_busy", 16'(busy), 16'h0);
        check("ovf_sticky", 16'(ovf_flag), 16'h1);

        // Reset during WRITEBACK of LDI r6,9
        mem[5] = 16'hE609;
        sb.push_back(8'h69);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();                  // D E WB
        check("rstwb_wb_rw", 16'(RegWrite), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstwb_rw", 16'(RegWrite), 16'h0);
        check("rstwb_pc", 16'(pc), 16'h0);
        check("rstwb_ovf", 16'(ovf_flag), 16'h0);
        check("rstwb_busy", 16'(busy), 16'h0);
        check("rstwb_wr", 16'(Wr), 16'h0);
        check("rstwb_data", 16'(Write_data), 16'h0);
        check("rstwb_rd1", 16'(Rd1), 16'h0);

        // run falls mid-EXECUTE: LDI r5,A still writes
        mem[0] = 16'hE50A;
        sb.push_back(8'h5A);
        run = 1'b1;
        tick(); tick(); tick();                  // F D E
        run = 1'b0;
        tick();                                  // WRITEBACK
        check("runfall_wb_rw", 16'(RegWrite), 16'h1);
        tick();
        check("runfall_idle_busy", 16'(busy), 16'h0);
        check("runfall_idle_pc", 16'(pc), 16'h1);

        // 16 instructions from pc=1: LDI r1,<pc>, wrapping through 0
        for (int i = 0; i < 16; i++) mem[i] = {8'hE1, 4'h0, 4'(i)};
        for (int i = 1; i < 17; i++) sb.push_back({4'h1, 4'(i)});
        run = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        check("wrap_pc", 16'(pc), 16'h0);
        check("wrap_last_rw", 16'(RegWrite), 16'h1);
        mem[1] = 16'hF000;
        tick();                                  // FETCH halt
        check("halt_fetch_pc", 16'(pc), 16'h1);
        tick(); tick();                          // DECODE, HALT
        check("halt_halted", 16'(halted), 16'h1);
        check("halt_busy", 16'(busy), 16'h0);
        check("halt_pc", 16'(pc), 16'h1);
        step = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("halt_stuck", 16'(halted), 16'h1);
        check("halt_pc_frozen", 16'(pc), 16'h1);
        check("halt_rw", 16'(RegWrite), 16'h0);
        step = 1'b0;
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst_halted", 16'(halted), 16'h0);
        check("halt_rst_pc", 16'(pc), 16'h0);
        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
